// File: rtl/dot_mac_seq_pkg.sv
// dot_mac_seq_pkg: shared fixed-point defaults, Q-format constants, accumulator sizing and state encoding
package dot_mac_seq_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRACT_WIDTH = 8;
  localparam logic [DEF_DATA_WIDTH-1:0] ONE = DEF_DATA_WIDTH'(1) << DEF_FRACT_WIDTH;
  localparam logic [DEF_DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
  localparam logic [DEF_DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};
  typedef enum logic {ACCUM, RESULT} state_t;
  function automatic int acc_w(input int dw, input int fw, input int guard);
    return 2 * dw - fw + guard;
  endfunction
endpackage

// File: rtl/dot_mac_mul.sv
// dot_mac_mul: signed Q-format multiply, floor rescale and sign-extend to accumulator width
module dot_mac_mul
  import dot_mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRACT_WIDTH = DEF_FRACT_WIDTH,
  parameter int ACC_W = acc_w(DEF_DATA_WIDTH, DEF_FRACT_WIDTH, 4)
) (
  input  logic [DATA_WIDTH-1:0]   x,
  input  logic [DATA_WIDTH-1:0]   w,
  output logic signed [ACC_W-1:0] p
);
  logic signed [2*DATA_WIDTH-1:0] full;
  always_comb begin
    full = $signed(x) * $signed(w);
    p = ACC_W'(full >>> FRACT_WIDTH);
  end
endmodule

// File: rtl/dot_mac_seq.sv
// dot_mac_seq: streaming fixed-point dot product plus bias; define SATURATE_OUT_EN to clamp instead of wrap on overflow
module dot_mac_seq
  import dot_mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRACT_WIDTH = DEF_FRACT_WIDTH,
  parameter int VEC_LEN = 4,
  parameter int ACC_GUARD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic [DATA_WIDTH-1:0] in_w,
  input  logic [DATA_WIDTH-1:0] in_bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_ovf
);
  localparam int ACC_W = acc_w(DATA_WIDTH, FRACT_WIDTH, ACC_GUARD);
  localparam int CNT_W = VEC_LEN > 1 ? $clog2(VEC_LEN) : 1;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, prod, sum;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d, narrow;
  logic out_ovf_q, out_ovf_d, beat, last, done, ovf;
  dot_mac_mul #(.DATA_WIDTH(DATA_WIDTH), .FRACT_WIDTH(FRACT_WIDTH), .ACC_W(ACC_W)) u_mul (
    .x(in_x),
    .w(in_w),
    .p(prod)
  );
  always_comb begin
    beat = in_valid && state_q == ACCUM;
    last = cnt_q == CNT_W'(VEC_LEN - 1);
    done = beat && last;
    sum = (cnt_q == '0 ? ACC_W'($signed(in_bias)) : acc_q) + prod;
    ovf = !(&sum[ACC_W-1:DATA_WIDTH-1] || ~|sum[ACC_W-1:DATA_WIDTH-1]);
`ifdef SATURATE_OUT_EN
    narrow = ovf ? {sum[ACC_W-1], {(DATA_WIDTH-1){~sum[ACC_W-1]}}} : sum[DATA_WIDTH-1:0];
`else
    narrow = sum[DATA_WIDTH-1:0];
`endif
    acc_d = beat ? sum : acc_q;
    cnt_d = beat ? (last ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
    state_d = state_q == ACCUM ? (done ? RESULT : ACCUM) : (out_ready ? ACCUM : RESULT);
    out_data_d = done ? narrow : out_data_q;
    out_ovf_d = done ? ovf : out_ovf_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      cnt_q <= '0;
      acc_q <= '0;
      out_data_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      out_data_q <= out_data_d;
      out_ovf_q <= out_ovf_d;
    end
  end
  assign in_ready = state_q == ACCUM;
  assign out_valid = state_q == RESULT;
  assign out_data = out_data_q;
  assign out_ovf = out_ovf_q;
endmodule
